// File: rtl/cv32e40x_ex_wb_buffer.sv
// -----------------------------------------------------------------------------
// cv32e40x_ex_wb_buffer
//
// EX/WB result buffer. Replaces the single EX/WB pipeline register with a
// DEPTH-entry in-order queue. EX can keep retiring instructions while WB is
// stalled on a late LSU response.
//
// Each accepted instruction stores:
//   - the write data, selected from N_UNIT functional-unit results by a
//     one-hot select;
//   - a register write enable, gated off for illegal instructions and for the
//     first half of a misaligned LSU access;
//   - the destination register, the PC and the illegal flag.
//
// The head entry drives the wb_* outputs directly from storage. ID can look
// up all buffered entries for forwarding.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ex_valid_i          EX presents an instruction
//   ex_ready_o          buffer accepts this cycle (pass-through on wb_ready_i when full)
//   unit_sel_i          one-hot functional-unit select
//   unit_result_i       packed unit results, unit k at [k*XLEN +: XLEN]
//   rf_we_i             instruction writes the register file
//   rf_waddr_i          destination register
//   pc_i                instruction PC
//   illegal_i           illegal instruction
//   lsu_misaligned_i    first half of a misaligned LSU access
//   kill_i              flush all entries
//   halt_i              block enqueue
//   wb_valid_o          head entry valid
//   wb_ready_i          WB consumes head
//   wb_rf_we_o          head write enable (gated)
//   wb_rf_waddr_o       head destination
//   wb_rf_wdata_o       head write data
//   wb_pc_o             head PC
//   wb_illegal_o        head illegal flag
//   count_o             number of occupied entries
//   fwd_raddr_i         ID operand address for the forwarding lookup
//   fwd_hit_o           an occupied, writing entry matches fwd_raddr_i
//   fwd_data_o          data of the youngest matching entry
// -----------------------------------------------------------------------------
module cv32e40x_ex_wb_buffer #(
    parameter int DEPTH     = 2,
    parameter int N_UNIT    = 4,
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ex_valid_i,
    output logic                         ex_ready_o,
    input  logic [N_UNIT-1:0]            unit_sel_i,
    input  logic [N_UNIT*XLEN-1:0]       unit_result_i,
    input  logic                         rf_we_i,
    input  logic [RF_ADDR_W-1:0]         rf_waddr_i,
    input  logic [XLEN-1:0]              pc_i,
    input  logic                         illegal_i,
    input  logic                         lsu_misaligned_i,
    input  logic                         kill_i,
    input  logic                         halt_i,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic                         wb_rf_we_o,
    output logic [RF_ADDR_W-1:0]         wb_rf_waddr_o,
    output logic [XLEN-1:0]              wb_rf_wdata_o,
    output logic [XLEN-1:0]              wb_pc_o,
    output logic                         wb_illegal_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic [RF_ADDR_W-1:0]         fwd_raddr_i,
    output logic                         fwd_hit_o,
    output logic [XLEN-1:0]              fwd_data_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // Keep at least one pointer bit so that DEPTH=1 still has legal vectors.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Pointers, occupancy and entry storage
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_nxt_s;

    logic                 mem_we_r    [DEPTH];
    logic [RF_ADDR_W-1:0] mem_waddr_r [DEPTH];
    logic [XLEN-1:0]      mem_wdata_r [DEPTH];
    logic [XLEN-1:0]      mem_pc_r    [DEPTH];
    logic                 mem_ill_r   [DEPTH];

    logic                 ex_ready_s;
    logic                 wb_valid_s;
    logic                 enq_s;
    logic                 enq_wr_s;
    logic                 deq_s;
    logic [XLEN-1:0]      sel_data_s;
    logic                 sel_we_s;

    logic                 fwd_hit_s;
    logic [XLEN-1:0]      fwd_data_s;
    logic [PTR_W-1:0]     fwd_slot_s;

    // Advance a pointer with an explicit wrap at DEPTH-1. This also works for
    // non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Physical slot of the entry that is 'ofs' places younger than the head.
    function automatic logic [PTR_W-1:0] slot_at(input logic [PTR_W-1:0] base,
                                                 input int unsigned     ofs);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + (PTR_W+1)'(ofs);
        if (sum >= (PTR_W+1)'(DEPTH)) begin
            sum = sum - (PTR_W+1)'(DEPTH);
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Handshakes. When the buffer is full, acceptance follows wb_ready_i
    // combinationally: the head drains on the same edge.
    assign wb_valid_s = (count_r != {CNT_W{1'b0}});
    assign ex_ready_s = kill_i | (~halt_i & ((count_r < DEPTH_C) | wb_ready_i));
    assign enq_s      = ex_valid_i & ex_ready_s;
    // A flush accepts the instruction but never stores it.
    assign enq_wr_s   = enq_s & ~kill_i;
    assign deq_s      = wb_valid_s & wb_ready_i;

    // Result select: OR of the selected unit results (zero when nothing is selected)
    always_comb begin
        sel_data_s = {XLEN{1'b0}};
        for (int k = 0; k < N_UNIT; k++) begin
            if (unit_sel_i[k]) begin
                sel_data_s = sel_data_s | unit_result_i[k*XLEN +: XLEN];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        sel_we_s = rf_we_i & ~illegal_i & ~lsu_misaligned_i;
    end

    // Next occupancy: +1 on a stored enqueue, -1 on a dequeue, unchanged on both
    always_comb begin
        count_nxt_s = count_r;
        case ({enq_wr_s, deq_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers. A flush returns both pointers to slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (kill_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (enq_wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (deq_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage: written at the tail on a stored enqueue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_we_r[i]    <= 1'b0;
                mem_waddr_r[i] <= {RF_ADDR_W{1'b0}};
                mem_wdata_r[i] <= {XLEN{1'b0}};
                mem_pc_r[i]    <= {XLEN{1'b0}};
                mem_ill_r[i]   <= 1'b0;
            end
        end else if (enq_wr_s) begin
            mem_we_r[wr_ptr_r]    <= sel_we_s;
            mem_waddr_r[wr_ptr_r] <= rf_waddr_i;
            mem_wdata_r[wr_ptr_r] <= sel_data_s;
            mem_pc_r[wr_ptr_r]    <= pc_i;
            mem_ill_r[wr_ptr_r]   <= illegal_i;
        end
    end

    // Forwarding lookup. Entries are visited from oldest to youngest, so the
    // last match is the youngest one. The instruction being enqueued this
    // cycle is not in storage yet, so it cannot match.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {XLEN{1'b0}};
        fwd_slot_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            fwd_slot_s = slot_at(rd_ptr_r, i);
            if ((CNT_W'(i) < count_r) && mem_we_r[fwd_slot_s] &&
                (mem_waddr_r[fwd_slot_s] == fwd_raddr_i) &&
                (fwd_raddr_i != {RF_ADDR_W{1'b0}})) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = mem_wdata_r[fwd_slot_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign ex_ready_o    = ex_ready_s;
    assign wb_valid_o    = wb_valid_s;
    assign wb_rf_we_o    = mem_we_r[rd_ptr_r];
    assign wb_rf_waddr_o = mem_waddr_r[rd_ptr_r];
    assign wb_rf_wdata_o = mem_wdata_r[rd_ptr_r];
    assign wb_pc_o       = mem_pc_r[rd_ptr_r];
    assign wb_illegal_o  = mem_ill_r[rd_ptr_r];
    assign count_o       = count_r;
    assign fwd_hit_o     = fwd_hit_s;
    assign fwd_data_o    = fwd_data_s;

    cv32e40x_ex_wb_buffer_sva #(
        .DEPTH  (DEPTH),
        .N_UNIT (N_UNIT),
        .CNT_W  (CNT_W)
    ) u_sva (
        .clk        (clk),
        .rst        (rst),
        .ex_valid_i (ex_valid_i),
        .unit_sel_i (unit_sel_i),
        .kill_i     (kill_i),
        .enq        (enq_s),
        .deq        (deq_s),
        .count      (count_r)
    );

endmodule

// -----------------------------------------------------------------------------
// cv32e40x_ex_wb_buffer_sva
//
// Property checker for the EX/WB buffer.
//   clk, rst     clock and reset
//   ex_valid_i   EX valid
//   unit_sel_i   unit select
//   kill_i       flush request
//   enq, deq     internal handshakes
//   count        occupancy
// -----------------------------------------------------------------------------
module cv32e40x_ex_wb_buffer_sva #(
    parameter int DEPTH  = 2,
    parameter int N_UNIT = 4,
    parameter int CNT_W  = 2
) (
    input logic              clk,
    input logic              rst,
    input logic              ex_valid_i,
    input logic [N_UNIT-1:0] unit_sel_i,
    input logic              kill_i,
    input logic              enq,
    input logic              deq,
    input logic [CNT_W-1:0]  count
);

    a_sel_onehot: assert property (@(posedge clk) disable iff (rst)
        ex_valid_i |-> $onehot0(unit_sel_i))
        else $error("unit_sel_i is not one-hot while ex_valid_i");

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (enq && !kill_i && (count == CNT_W'(DEPTH))) |-> deq)
        else $error("enqueue into a full buffer without a dequeue");

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH))
        else $error("occupancy exceeds DEPTH");

endmodule

// File: tb/tb_cv32e40x_ex_wb_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for cv32e40x_ex_wb_buffer with DEPTH=3, a non-power-of-two depth.
//
// Stimulus pushes the hand-computed expected entry into sb_q whenever an
// instruction is accepted. A monitor pops and compares an entry on every WB
// handshake. Directed checks cover occupancy, ready, forwarding, kill, halt
// and reset.
// -----------------------------------------------------------------------------
module tb_cv32e40x_ex_wb_buffer;

    localparam int DEPTH     = 3;
    localparam int N_UNIT    = 4;
    localparam int XLEN      = 32;
    localparam int RF_ADDR_W = 5;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       ex_valid_i = 1'b0;
    logic                       ex_ready_o;
    logic [N_UNIT-1:0]          unit_sel_i = '0;
    logic [N_UNIT*XLEN-1:0]     unit_result_i = '0;
    logic                       rf_we_i = 1'b0;
    logic [RF_ADDR_W-1:0]       rf_waddr_i = '0;
    logic [XLEN-1:0]            pc_i = '0;
    logic                       illegal_i = 1'b0;
    logic                       lsu_misaligned_i = 1'b0;
    logic                       kill_i = 1'b0;
    logic                       halt_i = 1'b0;
    logic                       wb_valid_o;
    logic                       wb_ready_i = 1'b0;
    logic                       wb_rf_we_o;
    logic [RF_ADDR_W-1:0]       wb_rf_waddr_o;
    logic [XLEN-1:0]            wb_rf_wdata_o;
    logic [XLEN-1:0]            wb_pc_o;
    logic                       wb_illegal_o;
    logic [CNT_W-1:0]           count_o;
    logic [RF_ADDR_W-1:0]       fwd_raddr_i = '0;
    logic                       fwd_hit_o;
    logic [XLEN-1:0]            fwd_data_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    cv32e40x_ex_wb_buffer #(
        .DEPTH     (DEPTH),
        .N_UNIT    (N_UNIT),
        .XLEN      (XLEN),
        .RF_ADDR_W (RF_ADDR_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid_i       (ex_valid_i),
        .ex_ready_o       (ex_ready_o),
        .unit_sel_i       (unit_sel_i),
        .unit_result_i    (unit_result_i),
        .rf_we_i          (rf_we_i),
        .rf_waddr_i       (rf_waddr_i),
        .pc_i             (pc_i),
        .illegal_i        (illegal_i),
        .lsu_misaligned_i (lsu_misaligned_i),
        .kill_i           (kill_i),
        .halt_i           (halt_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_rf_we_o       (wb_rf_we_o),
        .wb_rf_waddr_o    (wb_rf_waddr_o),
        .wb_rf_wdata_o    (wb_rf_wdata_o),
        .wb_pc_o          (wb_pc_o),
        .wb_illegal_o     (wb_illegal_o),
        .count_o          (count_o),
        .fwd_raddr_i      (fwd_raddr_i),
        .fwd_hit_o        (fwd_hit_o),
        .fwd_data_o       (fwd_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare the head against the scoreboard on every WB handshake
    always @(negedge clk) begin
        if (!rst && wb_valid_o && wb_ready_i && !kill_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got pc %h, expected no entry", wb_pc_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wb_pc",    wb_pc_o,                 e.pc);
                check("wb_waddr", {27'd0, wb_rf_waddr_o},  {27'd0, e.waddr});
                check("wb_wdata", wb_rf_wdata_o,           e.wdata);
                check("wb_we",    {31'd0, wb_rf_we_o},     {31'd0, e.we});
                check("wb_ill",   {31'd0, wb_illegal_o},   {31'd0, e.ill});
            end
        end
    end

    // Drive an instruction; 'res' goes to lane 'lane', the other lanes carry junk
    task automatic drive(input logic [31:0] pc, input logic [3:0] sel, input int lane,
                         input logic [31:0] res, input logic we, input logic [4:0] waddr,
                         input logic ill, input logic mis);
        ex_valid_i       = 1'b1;
        pc_i             = pc;
        unit_sel_i       = sel;
        rf_we_i          = we;
        rf_waddr_i       = waddr;
        illegal_i        = ill;
        lsu_misaligned_i = mis;
        for (int k = 0; k < N_UNIT; k++) begin
            unit_result_i[k*XLEN +: XLEN] = (k == lane) ? res : (32'hDEAD_BE00 | 32'(k));
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [4:0] waddr,
                            input logic [31:0] wdata, input logic we, input logic ill);
        exp_t e;
        e.pc = pc; e.waddr = waddr; e.wdata = wdata; e.we = we; e.ill = ill;
        sb_q.push_back(e);
    endtask

    // Present an instruction until accepted (bounded), record the expected entry
    task automatic send(input logic [31:0] pc, input logic [3:0] sel, input int lane,
                        input logic [31:0] res, input logic we, input logic [4:0] waddr,
                        input logic ill, input logic mis,
                        input logic [31:0] exp_wdata, input logic exp_we);
        int n;
        drive(pc, sel, lane, res, we, waddr, ill, mis);
        n = 0;
        @(negedge clk);
        while (!ex_ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ex_ready_o) begin
            errors++;
            $display("FAIL send_accept pc=%h: ex_ready_o stayed %b, expected 1", pc, ex_ready_o);
        end else begin
            push_exp(pc, waddr, exp_wdata, exp_we, ill);
        end
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
    endtask

    // Let WB consume everything (bounded), then check that the buffer is empty
    task automatic drain();
        int n;
        wb_ready_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (count_o != '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_count", {30'd0, count_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] stall_pat;
        stall_pat = 16'b1011_0010_0111_0100;

        // Reset state
        @(negedge clk);
        check("rst_count",    {30'd0, count_o},    32'd0);
        check("rst_valid",    {31'd0, wb_valid_o}, 32'd0);
        check("rst_wdata",    wb_rf_wdata_o,       32'd0);
        check("rst_pc",       wb_pc_o,             32'd0);
        check("rst_fwd_hit",  {31'd0, fwd_hit_o},  32'd0);
        check("rst_ready",    {31'd0, ex_ready_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single pass-through, one cycle latency
        wb_ready_i = 1'b1;
        send(32'h100, 4'b0001, 0, 32'hAAAA, 1'b1, 5'd5, 1'b0, 1'b0, 32'hAAAA, 1'b1);
        @(negedge clk);
        check("t1_valid", {31'd0, wb_valid_o}, 32'd1);
        check("t1_count", {30'd0, count_o},    32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_empty", {31'd0, wb_valid_o}, 32'd0);
        @(posedge clk); #1;

        // Fill to DEPTH, then full pass-through acceptance
        wb_ready_i = 1'b0;
        send(32'h100, 4'b0010, 1, 32'h1, 1'b1, 5'd1, 1'b0, 1'b0, 32'h1, 1'b1);
        send(32'h104, 4'b0010, 1, 32'h2, 1'b1, 5'd2, 1'b0, 1'b0, 32'h2, 1'b1);
        send(32'h108, 4'b0010, 1, 32'h3, 1'b1, 5'd3, 1'b0, 1'b0, 32'h3, 1'b1);
        drive(32'h10C, 4'b0010, 1, 32'h4, 1'b1, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        check("full_ready", {31'd0, ex_ready_o}, 32'd0);
        check("full_count", {30'd0, count_o},    32'd3);
        @(posedge clk); #1;
        wb_ready_i = 1'b1;
        @(negedge clk);
        check("full_pass_ready", {31'd0, ex_ready_o}, 32'd1);
        push_exp(32'h10C, 5'd4, 32'h4, 1'b1, 1'b0);
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        wb_ready_i = 1'b0;
        @(negedge clk);
        check("full_keep_count", {30'd0, count_o}, 32'd3);
        check("full_head_pc",    wb_pc_o,          32'h104);
        @(posedge clk); #1;
        drain();

        // Write-enable gating and output hold while stalled
        wb_ready_i = 1'b0;
        send(32'h200, 4'b0001, 0, 32'h55, 1'b1, 5'd3, 1'b1, 1'b0, 32'h55, 1'b0);
        send(32'h204, 4'b0001, 0, 32'h66, 1'b1, 5'd4, 1'b0, 1'b1, 32'h66, 1'b0);
        fwd_raddr_i = 5'd3;
        @(negedge clk);
        check("ill_we",      {31'd0, wb_rf_we_o},   32'd0);
        check("ill_flag",    {31'd0, wb_illegal_o}, 32'd1);
        check("ill_fwd_hit", {31'd0, fwd_hit_o},    32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_pc", wb_pc_o, 32'h200);
        @(posedge clk); #1;
        send(32'h208, 4'b0100, 2, 32'h77, 1'b1, 5'd10, 1'b0, 1'b0, 32'h77, 1'b1);
        drain();
        send(32'h20C, 4'b0000, 0, 32'h88, 1'b1, 5'd11, 1'b0, 1'b0, 32'h0, 1'b1);
        send(32'h210, 4'b1000, 3, 32'h99, 1'b0, 5'd9, 1'b0, 1'b0, 32'h99, 1'b0);
        drain();

        // Forwarding: youngest match wins, x0 never hits, enqueuing entry excluded
        wb_ready_i = 1'b0;
        send(32'h300, 4'b0001, 0, 32'h11, 1'b1, 5'd7, 1'b0, 1'b0, 32'h11, 1'b1);
        send(32'h304, 4'b0001, 0, 32'h22, 1'b1, 5'd7, 1'b0, 1'b0, 32'h22, 1'b1);
        fwd_raddr_i = 5'd7;
        @(negedge clk);
        check("fwd7_hit",  {31'd0, fwd_hit_o}, 32'd1);
        check("fwd7_data", fwd_data_o,         32'h22);
        fwd_raddr_i = 5'd0;
        #1;
        check("fwd0_hit",  {31'd0, fwd_hit_o}, 32'd0);
        check("fwd0_data", fwd_data_o,         32'd0);
        @(posedge clk); #1;
        drive(32'h308, 4'b0001, 0, 32'h33, 1'b1, 5'd8, 1'b0, 1'b0);
        fwd_raddr_i = 5'd8;
        @(negedge clk);
        check("fwd_enq_excl", {31'd0, fwd_hit_o}, 32'd0);
        check("fwd_enq_rdy",  {31'd0, ex_ready_o}, 32'd1);
        push_exp(32'h308, 5'd8, 32'h33, 1'b1, 1'b0);
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        @(negedge clk);
        check("fwd8_hit",  {31'd0, fwd_hit_o}, 32'd1);
        check("fwd8_data", fwd_data_o,         32'h33);
        @(posedge clk); #1;

        // Kill on a full buffer with simultaneous enqueue and dequeue
        drive(32'h400, 4'b0001, 0, 32'h44, 1'b1, 5'd12, 1'b0, 1'b0);
        kill_i     = 1'b1;
        wb_ready_i = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("kill_ready", {31'd0, ex_ready_o}, 32'd1);
        @(posedge clk); #1;
        kill_i     = 1'b0;
        ex_valid_i = 1'b0;
        wb_ready_i = 1'b0;
        @(negedge clk);
        check("kill_count", {30'd0, count_o},    32'd0);
        check("kill_valid", {31'd0, wb_valid_o}, 32'd0);
        check("kill_fwd",   {31'd0, fwd_hit_o},  32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("kill_no_new", {30'd0, count_o}, 32'd0);
        @(posedge clk); #1;

        // Halt blocks enqueue while dequeue continues
        send(32'h500, 4'b0001, 0, 32'h50, 1'b1, 5'd13, 1'b0, 1'b0, 32'h50, 1'b1);
        halt_i     = 1'b1;
        wb_ready_i = 1'b1;
        drive(32'h504, 4'b0001, 0, 32'h54, 1'b1, 5'd14, 1'b0, 1'b0);
        @(negedge clk);
        check("halt_ready", {31'd0, ex_ready_o}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("halt_count", {30'd0, count_o},    32'd0);
        check("halt_valid", {31'd0, wb_valid_o}, 32'd0);
        @(posedge clk); #1;
        halt_i     = 1'b0;
        ex_valid_i = 1'b0;

        // Stream of 10 with a fixed stall pattern; wraps the pointers several times
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(32'h600 + 32'(4*i), 4'(1 << (i % 4)), i % 4, 32'hC000_0000 + 32'(i),
                         1'b1, 5'(i + 1), 1'b0, 1'b0, 32'hC000_0000 + 32'(i), 1'b1);
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk); #1;
                    wb_ready_i = stall_pat[c % 16];
                end
                wb_ready_i = 1'b1;
            end
        join
        drain();

        // Asynchronous reset in the middle of traffic
        wb_ready_i = 1'b0;
        send(32'h800, 4'b0001, 0, 32'h80, 1'b1, 5'd15, 1'b0, 1'b0, 32'h80, 1'b1);
        send(32'h804, 4'b0001, 0, 32'h84, 1'b1, 5'd16, 1'b0, 1'b0, 32'h84, 1'b1);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("arst_count", {30'd0, count_o},    32'd0);
        check("arst_valid", {31'd0, wb_valid_o}, 32'd0);
        check("arst_pc",    wb_pc_o,             32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_ready_i = 1'b1;
        send(32'h900, 4'b0001, 0, 32'h90, 1'b1, 5'd17, 1'b0, 1'b0, 32'h90, 1'b1);
        drain();

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
